// File: rtl/seq_mult8.sv
// seq_mult8: 8x8 unsigned shift-and-add multiplier driving a ripple Adder8, one partial product per cycle.
module Adder8 (
    input  logic [7:0] A_in,
    input  logic [7:0] B_in,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);
    logic [8:0] c;
    assign c[0] = Cin;
    assign Cout = c[8];
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign Sum[i]   = A_in[i] ^ B_in[i] ^ c[i];
        assign c[i + 1] = (A_in[i] & B_in[i]) | (c[i] & (A_in[i] ^ B_in[i]));
    end
endmodule

module seq_mult8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d, a_q, a_d, q_q, q_d, sum;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        cout;
    Adder8 u_add (
        .A_in (a_q),
        .B_in (q_q[0] ? m_q : 8'h00),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                m_d     = multiplicand;
                q_d     = multiplier;
                a_d     = 8'h00;
                cnt_d   = 4'd0;
                state_d = CALC;
            end
            CALC: begin
                // Cout is shifted into A[7], so the carry register is implicitly zero.
                a_d   = {cout, sum[7:1]};
                q_d   = {sum[0], q_q[7:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    product_d = {cout, sum, q_q[7:1]};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 8'h00;
            a_q       <= 8'h00;
            q_q       <= 8'h00;
            cnt_q     <= 4'd0;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
    assign busy    = state_q == CALC;
    assign done    = state_q == DONE;
    assign product = product_q;
endmodule
